// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 32-bit word-wide memory port between the instruction-fetch
// requester (IF) and the load/store requester (DM). DM has fixed priority over IF.
// Handles RV32I byte enables, store lane replication, load extraction with sign/zero
// extension, misalignment / illegal-funct3 rejection and a bus timeout watchdog.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   if_req/if_addr                  fetch request (held until if_ready)
//   if_ready/if_inst/if_err         one-cycle fetch completion, instruction, error
//   dm_req/dm_we/dm_funct3/
//   dm_addr/dm_wdata                load/store request (held until dm_ready)
//   dm_ready/dm_rdata/dm_err        one-cycle data completion, extended load data, error
//   mem_req/mem_we/mem_be/
//   mem_addr/mem_wdata              memory request (word address, lane-replicated data)
//   mem_ack/mem_rdata               memory completion, read word valid with mem_ack
//
// All outputs are registered. A watchdog abandons an access after TIMEOUT_CYCLES cycles
// without mem_ack (0 disables it). Store completions return dm_rdata=0.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_WIDTH       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_inst,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_funct3,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StFetch, StData, StRespIf, StRespDm} state_e;

  state_e state_q, state_d;

  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
  logic                to_hit;

  // Attributes of the DM access in flight, needed to extract load data on mem_ack.
  logic       dm_we_q, dm_we_d;
  logic [2:0] dm_f3_q, dm_f3_d;
  logic [1:0] dm_off_q, dm_off_d;

  // Next values of the registered outputs.
  logic        if_ready_d, if_err_d, dm_ready_d, dm_err_d;
  logic [31:0] if_inst_d, dm_rdata_d;
  logic        mem_req_d, mem_we_d;
  logic [3:0]  mem_be_d;
  logic [31:0] mem_addr_d, mem_wdata_d;

  // Request decode.
  logic        dm_illegal, dm_misaligned, dm_bad;
  logic [3:0]  dm_be;
  logic [31:0] dm_wrep;

  // Load extraction.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    // Stores: only SB/SH/SW. Loads: LB/LH/LW/LBU/LHU.
    if (dm_we) begin
      dm_illegal = dm_funct3[2] | (dm_funct3[1:0] == 2'b11);
    end else begin
      dm_illegal = (dm_funct3[1:0] == 2'b11) | (dm_funct3 == 3'b110);
    end
    dm_misaligned = ((dm_funct3[1:0] == 2'b01) & dm_addr[0]) |
                    ((dm_funct3[1:0] == 2'b10) & (dm_addr[1:0] != 2'b00));
    dm_bad = dm_illegal | dm_misaligned;

    dm_be   = 4'b1111;
    dm_wrep = dm_wdata;
    if (dm_we) begin
      case (dm_funct3[1:0])
        2'b00: begin
          dm_be   = 4'b0001 << dm_addr[1:0];
          dm_wrep = {4{dm_wdata[7:0]}};
        end
        2'b01: begin
          dm_be   = dm_addr[1] ? 4'b1100 : 4'b0011;
          dm_wrep = {2{dm_wdata[15:0]}};
        end
        default: begin
          dm_be   = 4'b1111;
          dm_wrep = dm_wdata;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = mem_rdata[{dm_off_q, 3'b000} +: 8];
    ld_half = dm_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (dm_f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Watchdog: the counter holds the number of ack-less cycles already spent in the access.
  always_comb begin
    to_cnt_inc = to_cnt_q + TO_WIDTH'(1);
    to_hit     = (TIMEOUT_CYCLES != 0) && !mem_ack &&
                 (to_cnt_inc == TO_WIDTH'(TIMEOUT_CYCLES));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = '0;
    case (state_q)
      StIdle: begin
        if (dm_req) begin
          state_d = dm_bad ? StRespDm : StData;
        end else if (if_req) begin
          state_d = (if_addr[1:0] != 2'b00) ? StRespIf : StFetch;
        end
      end
      StFetch, StData: begin
        if (mem_ack || to_hit) begin
          state_d = (state_q == StFetch) ? StRespIf : StRespDm;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end
      StRespIf, StRespDm: state_d = StIdle;
      default:            state_d = StIdle;
    endcase
  end

  // Output logic: next values for the output registers.
  always_comb begin
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_inst_d   = if_inst;
    if_err_d    = if_err;
    dm_rdata_d  = dm_rdata;
    dm_err_d    = dm_err;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_be_d    = mem_be;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    dm_we_d     = dm_we_q;
    dm_f3_d     = dm_f3_q;
    dm_off_d    = dm_off_q;
    case (state_q)
      StIdle: begin
        if (dm_req) begin
          if (dm_bad) begin
            dm_ready_d = 1'b1;
            dm_err_d   = 1'b1;
            dm_rdata_d = '0;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = dm_we;
            mem_be_d    = dm_be;
            mem_addr_d  = {dm_addr[31:2], 2'b00};
            mem_wdata_d = dm_wrep;
            dm_we_d     = dm_we;
            dm_f3_d     = dm_funct3;
            dm_off_d    = dm_addr[1:0];
          end
        end else if (if_req) begin
          if (if_addr[1:0] != 2'b00) begin
            if_ready_d = 1'b1;
            if_err_d   = 1'b1;
            if_inst_d  = '0;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_be_d    = 4'b1111;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      StFetch: begin
        if (mem_ack || to_hit) begin
          mem_req_d  = 1'b0;
          if_ready_d = 1'b1;
          if_err_d   = !mem_ack;
          if_inst_d  = mem_ack ? mem_rdata : 32'h0;
        end
      end
      StData: begin
        if (mem_ack || to_hit) begin
          mem_req_d  = 1'b0;
          dm_ready_d = 1'b1;
          dm_err_d   = !mem_ack;
          dm_rdata_d = (mem_ack && !dm_we_q) ? ld_data : 32'h0;
        end
      end
      default: ;
    endcase
  end

  // Output and attribute registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ready  <= 1'b0;
      if_inst   <= '0;
      if_err    <= 1'b0;
      dm_ready  <= 1'b0;
      dm_rdata  <= '0;
      dm_err    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      dm_we_q   <= 1'b0;
      dm_f3_q   <= '0;
      dm_off_q  <= '0;
    end else begin
      if_ready  <= if_ready_d;
      if_inst   <= if_inst_d;
      if_err    <= if_err_d;
      dm_ready  <= dm_ready_d;
      dm_rdata  <= dm_rdata_d;
      dm_err    <= dm_err_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_be    <= mem_be_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      dm_we_q   <= dm_we_d;
      dm_f3_q   <= dm_f3_d;
      dm_off_q  <= dm_off_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by randomized
// fetch / load / store traffic checked against a behavioural model of the RV32I rules.
module tb_mem_bus_arbiter;

  logic        clk, rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_inst;
  logic        if_err;
  logic        dm_req, dm_we;
  logic [2:0]  dm_funct3;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_data, obs_wdata, obs_addr;
  logic [3:0]  obs_be;

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES(4),
    .TO_WIDTH      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_inst  (if_inst),
    .if_err   (if_err),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_funct3(dm_funct3),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_ready (dm_ready),
    .dm_rdata (dm_rdata),
    .dm_err   (dm_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL time_limit: observed no finish, required finish before 500us");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // ---- Behavioural model of the RV32I access rules ----
  function automatic int unsigned m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    if (we) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return ok && ((a % m_size(f3)) == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3,
                                      input logic [31:0] a);
    logic [7:0] t;
    if (!we) return 4'b1111;
    t = ((8'd1 << m_size(f3)) - 8'd1) << a[1:0];
    return t[3:0];
  endfunction

  // Lane i carries byte (i mod size) of the right-aligned store data.
  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % int'(m_size(f3))) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [63:0] v, mask;
    int unsigned n;
    n = m_size(f3);
    if (n == 4) return w;
    v    = {32'h0, w} >> (8 * a[1:0]);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---- Requester drivers ----
  task automatic start_if(input logic [31:0] a);
    if_req  = 1'b1;
    if_addr = a;
  endtask

  task automatic start_dm(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] w);
    dm_req    = 1'b1;
    dm_we     = we;
    dm_funct3 = f3;
    dm_addr   = a;
    dm_wdata  = w;
  endtask

  // Completes the pending request of one requester (already driven), acting as the
  // memory with 'delay' ack-less cycles, and checks it against the model.
  task automatic serve(input bit is_dm, input logic [31:0] word, input int unsigned delay);
    bit          legal;
    logic [31:0] eaddr, ewd, edata;
    logic [3:0]  ebe;
    logic        ewe;
    if (is_dm) begin
      legal = m_legal(dm_we, dm_funct3, dm_addr);
      eaddr = dm_addr & ~32'd3;
      ebe   = m_be(dm_we, dm_funct3, dm_addr);
      ewd   = m_wdata(dm_funct3, dm_wdata);
      ewe   = dm_we;
      edata = dm_we ? 32'h0 : m_load(dm_funct3, dm_addr, word);
    end else begin
      legal = (if_addr % 4) == 0;
      eaddr = if_addr;
      ebe   = 4'b1111;
      ewd   = 32'h0;
      ewe   = 1'b0;
      edata = word;
    end
    tick();
    if (!legal) begin
      chk("bad_no_mem", {31'h0, mem_req}, 32'h0);
      chk("bad_ready", {31'h0, is_dm ? dm_ready : if_ready}, 32'h1);
      chk("bad_err", {31'h0, is_dm ? dm_err : if_err}, 32'h1);
      chk("bad_data", is_dm ? dm_rdata : if_inst, 32'h0);
      edata = 32'h0;
    end else begin
      chk("grant_req", {31'h0, mem_req}, 32'h1);
      chk("grant_addr", mem_addr, eaddr);
      chk("grant_be", {28'h0, mem_be}, {28'h0, ebe});
      chk("grant_we", {31'h0, mem_we}, {31'h0, ewe});
      if (ewe) chk("grant_wdata", mem_wdata, ewd);
      obs_addr  = mem_addr;
      obs_be    = mem_be;
      obs_wdata = mem_wdata;
      for (int i = 0; i < int'(delay); i++) begin
        mem_rdata = $urandom;
        tick();
        chk("hold_req", {31'h0, mem_req}, 32'h1);
        chk("hold_addr", mem_addr, eaddr);
        chk("no_early_ready", {31'h0, dm_ready | if_ready}, 32'h0);
      end
      mem_rdata = word;
      mem_ack   = 1'b1;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      chk("ack_drop_req", {31'h0, mem_req}, 32'h0);
      chk("ack_ready", {31'h0, is_dm ? dm_ready : if_ready}, 32'h1);
      chk("ack_err", {31'h0, is_dm ? dm_err : if_err}, 32'h0);
      chk("ack_data", is_dm ? dm_rdata : if_inst, edata);
    end
    obs_data = is_dm ? dm_rdata : if_inst;
    if (is_dm) dm_req = 1'b0;
    else       if_req = 1'b0;
    tick();
    chk("ready_pulse", {31'h0, is_dm ? dm_ready : if_ready}, 32'h0);
    chk("data_hold", is_dm ? dm_rdata : if_inst, edata);
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_funct3 = '0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    // Reset state.
    #3;
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_if_ready", {31'h0, if_ready}, 32'h0);
    chk("rst_dm_ready", {31'h0, dm_ready}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Stray ack in IDLE has no effect.
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_req", {31'h0, mem_req}, 32'h0);
    chk("stray_ack_ready", {31'h0, if_ready | dm_ready}, 32'h0);
    tick();

    // 1: fetch with two ack-less cycles.
    start_if(32'h100);
    serve(1'b0, 32'h00000013, 2);
    chk("t1_inst", obs_data, 32'h00000013);
    chk("t1_addr", obs_addr, 32'h100);

    // 2: simultaneous requests, DM wins.
    start_if(32'h104);
    start_dm(1'b0, 3'b010, 32'h200, 32'h0);
    serve(1'b1, 32'hCAFEF00D, 0);
    chk("t2_dm_first", obs_addr, 32'h200);
    serve(1'b0, 32'h00100093, 0);
    chk("t2_if_second", obs_addr, 32'h104);

    // 3: store lane replication.
    start_dm(1'b1, 3'b000, 32'h203, 32'h000000AB);
    serve(1'b1, 32'h0, 1);
    chk("t3_sb_be", {28'h0, obs_be}, 32'h8);
    chk("t3_sb_wdata", obs_wdata, 32'hABABABAB);
    start_dm(1'b1, 3'b001, 32'h202, 32'h00001234);
    serve(1'b1, 32'h0, 0);
    chk("t3_sh_be", {28'h0, obs_be}, 32'hC);
    chk("t3_sh_wdata", obs_wdata, 32'h12341234);

    // 4: load extraction.
    start_dm(1'b0, 3'b000, 32'h201, 32'h0);
    serve(1'b1, 32'h80018000, 0);
    chk("t4_lb", obs_data, 32'hFFFFFF80);
    start_dm(1'b0, 3'b100, 32'h201, 32'h0);
    serve(1'b1, 32'h80018000, 1);
    chk("t4_lbu", obs_data, 32'h00000080);
    start_dm(1'b0, 3'b001, 32'h202, 32'h0);
    serve(1'b1, 32'h80018000, 0);
    chk("t4_lh", obs_data, 32'hFFFF8001);
    start_dm(1'b0, 3'b101, 32'h202, 32'h0);
    serve(1'b1, 32'h80018000, 2);
    chk("t4_lhu", obs_data, 32'h00008001);

    // 5: rejected accesses never reach memory.
    start_dm(1'b0, 3'b010, 32'h202, 32'h0);
    serve(1'b1, 32'h0, 0);
    start_dm(1'b0, 3'b111, 32'h200, 32'h0);
    serve(1'b1, 32'h0, 0);
    start_if(32'h102);
    serve(1'b0, 32'h0, 0);

    // 6: watchdog, then reset mid-access.
    start_dm(1'b0, 3'b010, 32'h300, 32'h0);
    tick();
    chk("t6_req_c1", {31'h0, mem_req}, 32'h1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("t6_req_held", {31'h0, mem_req}, 32'h1);
    end
    tick();
    chk("t6_req_drop", {31'h0, mem_req}, 32'h0);
    chk("t6_ready", {31'h0, dm_ready}, 32'h1);
    chk("t6_err", {31'h0, dm_err}, 32'h1);
    chk("t6_data", dm_rdata, 32'h0);
    dm_req = 1'b0;
    tick();

    start_dm(1'b0, 3'b010, 32'h300, 32'h0);
    tick();
    chk("t6r_req", {31'h0, mem_req}, 32'h1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6r_async_drop", {31'h0, mem_req}, 32'h0);
    chk("t6r_no_ready", {31'h0, dm_ready}, 32'h0);
    dm_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6r_quiet", {31'h0, dm_ready | if_ready | mem_req}, 32'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 80; n++) begin
      int unsigned mode;
      logic [31:0] ia, da;
      mode = $urandom_range(0, 2);
      ia   = $urandom;
      if ($urandom_range(0, 3) != 0) ia[1:0] = 2'b00;
      da   = $urandom;
      if (mode != 1) start_if(ia);
      if (mode != 0) start_dm(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), da, $urandom);
      if (mode != 0) serve(1'b1, $urandom, $urandom_range(0, 2));
      if (mode != 1) serve(1'b0, $urandom, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
